// File: rtl/cic_ctrl_pkg.sv
// Shared types and constants for the CIC decimator sequencing controller.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } cic_ctrl_state_t;

  localparam int MIN_RATIO = 2;
  localparam int CIC_ORDER = 3;

endpackage

// File: rtl/cic_out_fifo2.sv
// Two-entry output buffer between the capture point and the valid/ready consumer.
module cic_out_fifo2 #(
  parameter int W = 25
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_data    = r_mem[r_rd_ptr];
  // A pop frees the slot in the same cycle, so a full buffer can still take a push.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy; flush empties the buffer without touching storage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the modulator -> CIC decimator chain: clear, settle, decimate, deliver.
//   state  | meaning
//   IDLE   | integrators frozen, waiting for enable
//   CLEAR  | one-cycle pulse zeroing CIC integrator/comb registers
//   SETTLE | decimating, discarding start-up samples
//   RUN    | decimating, captured samples go to the output buffer
module cic_decim_ctrl import cic_ctrl_pkg::*; #(
  parameter int OUT_W          = 25,
  parameter int RATIO_W        = 10,
  parameter int DEFAULT_RATIO  = 64,
  parameter int COMB_LAT       = 1,
  parameter int SETTLE_OUTPUTS = CIC_ORDER
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [RATIO_W-1:0] i_ratio_cfg,
  input  logic               i_ratio_load,
  input  logic [OUT_W-1:0]   i_cic_data,
  output logic               o_cic_clear,
  output logic               o_integ_en,
  output logic               o_comb_strobe,
  output logic [OUT_W-1:0]   o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_settling,
  output logic               o_overrun,
  input  logic               i_ovr_clr
);

  localparam int DISC_W = $clog2(SETTLE_OUTPUTS + 1);

  cic_ctrl_state_t    r_state;
  logic [RATIO_W-1:0] r_phase;
  logic [RATIO_W-1:0] r_ratio_q;
  logic [RATIO_W-1:0] r_ratio_pend;
  logic               r_pend;
  logic [DISC_W-1:0]  r_disc;
  logic [COMB_LAT-1:0] r_cap_sr;
  logic               r_cic_clear;
  logic               r_integ_en;
  logic               r_comb_strobe;
  logic               r_settling;
  logic               r_overrun;

  logic               w_wrap;
  logic               w_apply;
  logic               w_cap;
  logic               w_next_active;
  logic [RATIO_W-1:0] w_phase_nxt;
  logic [RATIO_W-1:0] w_ratio_nxt;
  logic               w_strobe_nxt;
  logic [RATIO_W-1:0] w_ratio_clamped;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;

  // The strobe is registered, so the wrap condition is evaluated one cycle ahead.
  assign w_wrap          = r_comb_strobe;
  assign w_apply         = w_wrap && r_pend;
  assign w_cap           = r_cap_sr[COMB_LAT-1];
  assign w_next_active   = i_enable && (r_state != IDLE);
  assign w_phase_nxt     = ((r_state == CLEAR) || w_wrap) ? '0 : r_phase + RATIO_W'(1);
  assign w_ratio_nxt     = w_apply ? r_ratio_pend : r_ratio_q;
  assign w_strobe_nxt    = w_next_active && (w_phase_nxt == w_ratio_nxt - RATIO_W'(1));
  assign w_ratio_clamped = (i_ratio_cfg < RATIO_W'(MIN_RATIO)) ? RATIO_W'(MIN_RATIO) : i_ratio_cfg;
  assign w_flush         = !i_enable && (r_state != IDLE);
  assign w_push          = w_cap && (r_state == RUN) && i_enable;
  assign w_pop           = !w_empty && i_out_ready;
  assign w_drop          = w_push && w_full && !w_pop;

  // Control FSM with registered outputs; losing enable overrides every transition.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_phase       <= '0;
      r_disc        <= '0;
      r_cic_clear   <= 1'b0;
      r_integ_en    <= 1'b0;
      r_comb_strobe <= 1'b0;
      r_settling    <= 1'b0;
    end else begin
      r_cic_clear   <= 1'b0;
      r_comb_strobe <= w_strobe_nxt;
      if (r_state != IDLE) r_phase <= w_phase_nxt;
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state     <= CLEAR;
            r_cic_clear <= 1'b1;
            r_settling  <= 1'b1;
          end
        end
        CLEAR: begin
          r_disc     <= DISC_W'(SETTLE_OUTPUTS);
          r_state    <= SETTLE;
          r_integ_en <= 1'b1;
        end
        SETTLE: begin
          if (w_apply) begin
            r_disc <= DISC_W'(SETTLE_OUTPUTS);
          end else if (w_cap) begin
            r_disc <= r_disc - DISC_W'(1);
            if (r_disc <= DISC_W'(1)) begin
              r_state    <= RUN;
              r_settling <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_apply) begin
            r_disc     <= DISC_W'(SETTLE_OUTPUTS);
            r_state    <= SETTLE;
            r_settling <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_flush) begin
        r_state     <= IDLE;
        r_cic_clear <= 1'b0;
        r_integ_en  <= 1'b0;
        r_settling  <= 1'b0;
      end
    end
  end

  // Ratio register: immediate in IDLE, otherwise deferred to the next decimation boundary.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ratio_q    <= RATIO_W'(DEFAULT_RATIO);
      r_ratio_pend <= RATIO_W'(DEFAULT_RATIO);
      r_pend       <= 1'b0;
    end else begin
      if (w_apply || ((r_state == IDLE) && r_pend)) begin
        r_ratio_q <= r_ratio_pend;
        r_pend    <= 1'b0;
      end
      if (i_ratio_load) begin
        r_ratio_pend <= w_ratio_clamped;
        if (r_state == IDLE) begin
          r_ratio_q <= w_ratio_clamped;
          r_pend    <= 1'b0;
        end else begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  // Comb-to-data latency line; the tap marks the cycle cic_data is valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_cap_sr <= '0;
    else if (w_flush) r_cap_sr <= '0;
    else              r_cap_sr <= COMB_LAT'({r_cap_sr, r_comb_strobe});
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        r_overrun <= 1'b0;
    else if (w_drop)    r_overrun <= 1'b1;
    else if (i_ovr_clr) r_overrun <= 1'b0;
  end

  cic_out_fifo2 #(.W(OUT_W)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_cic_data),
    .o_data  (o_out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_cic_clear   = r_cic_clear;
  assign o_integ_en    = r_integ_en;
  assign o_comb_strobe = r_comb_strobe;
  assign o_out_valid   = !w_empty;
  assign o_settling    = r_settling;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: start-up timing table plus overrun, ratio-change,
// disable and reset sequences. cic_data is a free-running ramp so captures are traceable.
module tb_cic_decim_ctrl;

  localparam int OUT_W   = 25;
  localparam int RATIO_W = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [RATIO_W-1:0] ratio_cfg;
  logic               ratio_load;
  logic [OUT_W-1:0]   cic_data;
  logic               cic_clear;
  logic               integ_en;
  logic               comb_strobe;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               settling;
  logic               overrun;
  logic               ovr_clr;
  logic [OUT_W-1:0]   cyc = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1'b1;
  assign cic_data = cyc;

  cic_decim_ctrl #(
    .OUT_W(OUT_W), .RATIO_W(RATIO_W), .DEFAULT_RATIO(64), .COMB_LAT(1), .SETTLE_OUTPUTS(3)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_ratio_cfg   (ratio_cfg),
    .i_ratio_load  (ratio_load),
    .i_cic_data    (cic_data),
    .o_cic_clear   (cic_clear),
    .o_integ_en    (integ_en),
    .o_comb_strobe (comb_strobe),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_settling    (settling),
    .o_overrun     (overrun),
    .i_ovr_clr     (ovr_clr)
  );

  typedef struct {
    bit from_reset;
    int cfg;
    int period;
    int first_valid;
    int settle_end;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input string name, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (comb_strobe) found = 1'b1;
    end
    chk(name, int'(found), 1);
  endtask

  // Follows one start-up from the CLEAR pulse (t=0) until n_out samples are delivered.
  task automatic observe(input string tag, input int r, input int exp_first,
                         input int exp_settle_end, input int n_out);
    int t = 0, nstb = 0, nout = 0, first_valid = -1, settle_end = -1;
    int stb1 = -1, stb2 = -1, extra_clr = 0, errs = 0;
    int expq[$];
    bit found = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cic_clear) found = 1'b1;
    end
    chk({tag, "_clear_seen"}, int'(found), 1);
    if (!found) return;
    chk({tag, "_settling_t0"}, int'(settling), 1);
    chk({tag, "_integ_t0"}, int'(integ_en), 0);
    while (nout < n_out && t < exp_first + n_out * r + 20) begin
      @(negedge clk);
      t++;
      if (t == 1) chk({tag, "_integ_t1"}, int'(integ_en), 1);
      if (cic_clear) extra_clr++;
      if (comb_strobe) begin
        nstb++;
        if (nstb == 1) stb1 = t;
        if (nstb == 2) stb2 = t;
        if (nstb >= 4) expq.push_back(int'(cic_data) + 1);
      end
      if (!settling && settle_end < 0) settle_end = t;
      if (out_valid) begin
        if (first_valid < 0) first_valid = t;
        nout++;
        if (expq.size() == 0) errs++;
        else if (int'(out_data) != expq.pop_front()) errs++;
      end
    end
    chk({tag, "_strobe1"}, stb1, r);
    chk({tag, "_strobe2"}, stb2, 2 * r);
    chk({tag, "_settle_end"}, settle_end, exp_settle_end);
    chk({tag, "_first_valid"}, first_valid, exp_first);
    chk({tag, "_n_out"}, nout, n_out);
    chk({tag, "_data_errs"}, errs, 0);
    chk({tag, "_extra_clear"}, extra_clr, 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    logic [OUT_W-1:0] d0, d1, bexp, bdata;
    int derr;
    int bstb[$];
    int brise, bfall, bvalid;

    vecs[0] = '{from_reset: 1'b1, cfg: 0,  period: 64, first_valid: 258, settle_end: 194};
    vecs[1] = '{from_reset: 1'b0, cfg: 0,  period: 2,  first_valid: 10,  settle_end: 8};
    vecs[2] = '{from_reset: 1'b0, cfg: 1,  period: 2,  first_valid: 10,  settle_end: 8};
    vecs[3] = '{from_reset: 1'b0, cfg: 3,  period: 3,  first_valid: 14,  settle_end: 11};
    vecs[4] = '{from_reset: 1'b0, cfg: 16, period: 16, first_valid: 66,  settle_end: 50};

    reset = 1'b1; enable = 1'b1; ratio_cfg = '0; ratio_load = 1'b0;
    out_ready = 1'b1; ovr_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cic_clear", int'(cic_clear), 0);
    chk("rst_integ_en", int'(integ_en), 0);
    chk("rst_comb_strobe", int'(comb_strobe), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_settling", int'(settling), 0);
    chk("rst_overrun", int'(overrun), 0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].from_reset) begin
        reset = 1'b1; enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        enable = 1'b0;
        repeat (2) @(negedge clk);
        ratio_cfg = RATIO_W'(vecs[i].cfg); ratio_load = 1'b1;
        @(negedge clk);
        ratio_load = 1'b0; enable = 1'b1;
      end
      observe($sformatf("vec%0d", i), vecs[i].period, vecs[i].first_valid,
              vecs[i].settle_end, 3);
    end

    // Back-pressure at ratio 16: two samples held, third dropped, head stable.
    wait_strobe("a_strobe", 40);
    d0 = cic_data + 1'b1; d1 = '0; derr = 0;
    out_ready = 1'b0;
    for (int off = 1; off <= 64; off++) begin
      @(negedge clk);
      if (off == 16) begin
        chk("a_strobe_period", int'(comb_strobe), 1);
        d1 = cic_data + 1'b1;
      end
      if (off == 33) chk("a_ovr_before_drop", int'(overrun), 0);
      if (off == 34) chk("a_ovr_after_drop", int'(overrun), 1);
      if (off >= 2 && (!out_valid || out_data != d0)) derr++;
    end
    chk("a_head_stable", derr, 0);
    wait_strobe("a_strobe2", 40);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    chk("a_set_wins", int'(overrun), 1);
    @(negedge clk);
    chk("a_ovr_clr", int'(overrun), 0);
    chk("a_head0", int'(out_data), int'(d0));
    ovr_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("a_valid1", int'(out_valid), 1);
    chk("a_head1", int'(out_data), int'(d1));
    @(negedge clk);
    chk("a_drained", int'(out_valid), 0);

    // Disable with one sample buffered and overrun set, then restart.
    wait_strobe("c_strobe", 40);
    out_ready = 1'b0;
    repeat (34) @(negedge clk);
    chk("c_ovr_set", int'(overrun), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; enable = 1'b0;
    chk("c_one_buffered", int'(out_valid), 1);
    @(negedge clk);
    chk("c_valid_flushed", int'(out_valid), 0);
    chk("c_integ_off", int'(integ_en), 0);
    chk("c_ovr_kept", int'(overrun), 1);
    chk("c_settling_off", int'(settling), 0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0; enable = 1'b1;
    observe("c_reen", 16, 66, 50, 2);

    // Run at 64, then two loads mid-period (last one, 16, must win).
    enable = 1'b0;
    repeat (2) @(negedge clk);
    ratio_cfg = 10'd64; ratio_load = 1'b1;
    @(negedge clk);
    ratio_load = 1'b0; enable = 1'b1;
    observe("b_run64", 64, 258, 194, 1);
    wait_strobe("b_strobe", 80);
    repeat (10) @(negedge clk);
    ratio_cfg = 10'd20; ratio_load = 1'b1;
    @(negedge clk);
    ratio_load = 1'b0;
    @(negedge clk);
    ratio_cfg = 10'd16; ratio_load = 1'b1;
    @(negedge clk);
    ratio_load = 1'b0;
    brise = -1; bfall = -1; bvalid = -1; bexp = '0; bdata = '0;
    for (int off = 14; off <= 130; off++) begin
      @(negedge clk);
      if (comb_strobe) bstb.push_back(off);
      if (off == 113) bexp = cic_data;
      if (settling && brise < 0) brise = off;
      if (!settling && brise >= 0 && bfall < 0) bfall = off;
      if (out_valid && bvalid < 0) begin
        bvalid = off;
        bdata  = out_data;
      end
    end
    chk("b_n_strobes", bstb.size(), 5);
    if (bstb.size() >= 3) begin
      chk("b_apply_wrap", bstb[0], 64);
      chk("b_new_strobe1", bstb[1], 80);
      chk("b_new_strobe2", bstb[2], 96);
    end
    chk("b_settle_rise", brise, 65);
    chk("b_settle_fall", bfall, 98);
    chk("b_first_valid", bvalid, 114);
    chk("b_first_data", int'(bdata), int'(bexp));

    // Asynchronous reset between clock edges with overrun set.
    out_ready = 1'b0;
    repeat (70) @(negedge clk);
    chk("d_pre_ovr", int'(overrun), 1);
    @(posedge clk);
    #2;
    reset = 1'b1; enable = 1'b0;
    #1;
    chk("d_ovr", int'(overrun), 0);
    chk("d_valid", int'(out_valid), 0);
    chk("d_integ", int'(integ_en), 0);
    chk("d_settling", int'(settling), 0);
    chk("d_data", int'(out_data), 0);
    chk("d_strobe", int'(comb_strobe), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("d_idle_integ", int'(integ_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
